// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolution with a direct-mapped BTB and 2-bit direction counters.
// Fetch gets a combinational next-PC prediction; mispredicts raise a registered redirect.
module branch_resolve_bht #(
  parameter int WIDTH     = 32,
  parameter int IDX_BITS  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH-1:0]     i_F_PC,
  output logic [WIDTH-1:0]     o_F_PPC,
  output logic                 o_F_Taken,
  input  logic                 i_EX_Valid,
  input  logic [WIDTH-1:0]     i_EX_PC,
  input  logic [WIDTH-1:0]     i_ALU_rslt,
  input  logic                 i_Taken,
  input  logic [WIDTH-1:0]     i_PPC,
  input  logic                 i_Clear_Tbl,
  output logic                 o_Redirect,
  output logic [WIDTH-1:0]     o_New_PC,
  output logic                 o_Ready,
  output logic [CNT_WIDTH-1:0] o_Mispred_Cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = WIDTH - IDX_BITS - 2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [WIDTH-1:0]    target_q [ENTRIES];
  logic [1:0]          cnt_q    [ENTRIES];

  logic                run;
  logic [IDX_BITS-1:0] f_idx, ex_idx;
  logic [TAG_W-1:0]    f_tag, ex_tag;
  logic                f_hit, ex_hit;
  logic                resolve, mispred, tbl_we;
  logic [WIDTH-1:0]    actual;
  logic                unused_pc_low;

  assign unused_pc_low = ^{i_F_PC[1:0], i_EX_PC[1:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep pointer wraps back to 0 naturally after the last entry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_Clear_Tbl) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  assign run     = (state_q == ST_RUN);
  assign o_Ready = run;

  assign f_idx     = i_F_PC[IDX_BITS+1:2];
  assign f_tag     = i_F_PC[WIDTH-1:IDX_BITS+2];
  assign f_hit     = run && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign o_F_Taken = f_hit && cnt_q[f_idx][1];
  assign o_F_PPC   = o_F_Taken ? target_q[f_idx] : i_F_PC + WIDTH'(4);

  // The instruction sitting in EX while a redirect is out is wrong-path.
  assign resolve = i_EX_Valid && !o_Redirect;
  assign actual  = i_Taken ? i_ALU_rslt : i_EX_PC + WIDTH'(4);
  assign mispred = resolve && (actual != i_PPC);
  assign tbl_we  = resolve && run && !i_Clear_Tbl;
  assign ex_idx  = i_EX_PC[IDX_BITS+1:2];
  assign ex_tag  = i_EX_PC[WIDTH-1:IDX_BITS+2];
  assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (!run) begin
      valid_q[ptr_q] <= 1'b0;
    end else if (tbl_we && !ex_hit && i_Taken) begin
      valid_q[ex_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: valid gates every use of it.
  always_ff @(posedge i_clk) begin
    if (tbl_we) begin
      if (ex_hit) begin
        if (i_Taken) begin
          cnt_q[ex_idx]    <= (cnt_q[ex_idx] == 2'b11) ? 2'b11 : cnt_q[ex_idx] + 2'b01;
          target_q[ex_idx] <= i_ALU_rslt;
        end else begin
          cnt_q[ex_idx]    <= (cnt_q[ex_idx] == 2'b00) ? 2'b00 : cnt_q[ex_idx] - 2'b01;
        end
      end else if (i_Taken) begin
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= i_ALU_rslt;
        cnt_q[ex_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_Redirect    <= 1'b0;
      o_New_PC      <= '0;
      o_Mispred_Cnt <= '0;
    end else begin
      o_Redirect <= mispred;
      if (mispred) o_New_PC <= actual;
      if (mispred && !(&o_Mispred_Cnt)) o_Mispred_Cnt <= o_Mispred_Cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed scoreboard bench for branch_resolve_bht (WIDTH=32, IDX_BITS=4).
module tb_branch_resolve_bht;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_F_PC = '0;
  logic [31:0] o_F_PPC;
  logic        o_F_Taken;
  logic        i_EX_Valid = 1'b0;
  logic [31:0] i_EX_PC = '0;
  logic [31:0] i_ALU_rslt = '0;
  logic        i_Taken = 1'b0;
  logic [31:0] i_PPC = '0;
  logic        i_Clear_Tbl = 1'b0;
  logic        o_Redirect;
  logic [31:0] o_New_PC;
  logic        o_Ready;
  logic [15:0] o_Mispred_Cnt;

  typedef struct {
    logic        red;
    logic [31:0] pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic        exp_red_now = 1'b0;
  logic [15:0] exp_cnt = '0;

  branch_resolve_bht #(.WIDTH(32), .IDX_BITS(4), .CNT_WIDTH(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_F_PC(i_F_PC), .o_F_PPC(o_F_PPC), .o_F_Taken(o_F_Taken),
    .i_EX_Valid(i_EX_Valid), .i_EX_PC(i_EX_PC), .i_ALU_rslt(i_ALU_rslt),
    .i_Taken(i_Taken), .i_PPC(i_PPC), .i_Clear_Tbl(i_Clear_Tbl),
    .o_Redirect(o_Redirect), .o_New_PC(o_New_PC), .o_Ready(o_Ready),
    .o_Mispred_Cnt(o_Mispred_Cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one edge, then retire any scoreboard entry for the resolve just clocked.
  task automatic cycle();
    exp_t e;
    @(posedge i_clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("redirect", {31'b0, o_Redirect}, {31'b0, e.red});
      if (e.red) checkOutput("new_pc", o_New_PC, e.pc);
      checkOutput("mispred_cnt", {16'b0, o_Mispred_Cnt}, {16'b0, e.cnt});
      exp_red_now = e.red;
    end else begin
      exp_red_now = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic taken,
                               input logic [31:0] alu, input logic [31:0] ppc);
    exp_t        e;
    logic [31:0] act;
    act   = taken ? alu : pc + 32'd4;
    e.red = !exp_red_now && (act != ppc);
    if (e.red && exp_cnt != 16'hFFFF) exp_cnt++;
    e.pc  = act;
    e.cnt = exp_cnt;
    sb.push_back(e);
    i_EX_Valid = 1'b1;
    i_EX_PC    = pc;
    i_Taken    = taken;
    i_ALU_rslt = alu;
    i_PPC      = ppc;
    cycle();
    i_EX_Valid = 1'b0;
  endtask

  task automatic checkLookup(input string tag, input logic [31:0] pc,
                             input logic [31:0] ppc, input logic taken);
    i_F_PC = pc;
    #1;
    checkOutput({tag, "_ppc"}, o_F_PPC, ppc);
    checkOutput({tag, "_taken"}, {31'b0, o_F_Taken}, {31'b0, taken});
  endtask

  task automatic waitInit(input string tag);
    for (int i = 0; i < 16; i++) begin
      checkOutput({tag, "_ready_low"}, {31'b0, o_Ready}, 32'd0);
      cycle();
    end
    checkOutput({tag, "_ready_high"}, {31'b0, o_Ready}, 32'd1);
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst_redirect", {31'b0, o_Redirect}, 32'd0);
    checkOutput("rst_new_pc", o_New_PC, 32'd0);
    checkOutput("rst_cnt", {16'b0, o_Mispred_Cnt}, 32'd0);
    checkOutput("rst_ready", {31'b0, o_Ready}, 32'd0);
    i_rst_n = 1'b1;
    checkLookup("init_lookup", 32'h100, 32'h104, 1'b0);
    waitInit("boot");
    checkOutput("boot_cnt", {16'b0, o_Mispred_Cnt}, 32'd0);
    checkLookup("cold_lookup", 32'h100, 32'h104, 1'b0);

    // First taken branch misses, allocates and redirects.
    applyStimulus(32'h100, 1'b1, 32'h200, 32'h104);
    checkLookup("alloc_lookup", 32'h100, 32'h200, 1'b1);
    checkLookup("alias_lookup", 32'h140, 32'h144, 1'b0);
    cycle();

    // Saturate the counter, then check hysteresis.
    repeat (3) applyStimulus(32'h100, 1'b1, 32'h200, 32'h200);
    applyStimulus(32'h100, 1'b0, 32'h200, 32'h200);
    checkLookup("hyst1_lookup", 32'h100, 32'h200, 1'b1);
    cycle();
    applyStimulus(32'h100, 1'b0, 32'h200, 32'h200);
    checkLookup("hyst2_lookup", 32'h100, 32'h104, 1'b0);
    cycle();

    // Back-to-back mispredicts: the second is in the redirect shadow.
    applyStimulus(32'h304, 1'b1, 32'h400, 32'h308);
    applyStimulus(32'h308, 1'b1, 32'h500, 32'h30C);
    checkLookup("shadow_lookup", 32'h308, 32'h30C, 1'b0);
    checkLookup("shadow_alloc", 32'h304, 32'h400, 1'b1);
    cycle();

    // Clear request: 16-cycle sweep, lookups miss, a resolve still redirects.
    i_Clear_Tbl = 1'b1;
    cycle();
    i_Clear_Tbl = 1'b0;
    checkLookup("clear_lookup", 32'h304, 32'h308, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("clear_ready_low", {31'b0, o_Ready}, 32'd0);
      if (i == 3) applyStimulus(32'h500, 1'b1, 32'h600, 32'h504);
      else cycle();
    end
    checkOutput("clear_ready_high", {31'b0, o_Ready}, 32'd1);
    checkLookup("post_clear_304", 32'h304, 32'h308, 1'b0);
    checkLookup("post_clear_500", 32'h500, 32'h504, 1'b0);
    checkLookup("post_clear_100", 32'h100, 32'h104, 1'b0);

    // Reset in the middle of a sweep restarts it from entry 0.
    i_Clear_Tbl = 1'b1;
    cycle();
    i_Clear_Tbl = 1'b0;
    repeat (7) cycle();
    i_rst_n = 1'b0;
    exp_cnt = '0;
    #1;
    checkOutput("rst2_cnt", {16'b0, o_Mispred_Cnt}, 32'd0);
    checkOutput("rst2_ready", {31'b0, o_Ready}, 32'd0);
    cycle();
    i_rst_n = 1'b1;
    waitInit("rst2");

    // Wrap-around fall-through: 0xFFFFFFFC+4 == 0, so no redirect.
    checkLookup("wrap_lookup", 32'hFFFF_FFFC, 32'h0, 1'b0);
    applyStimulus(32'hFFFF_FFFC, 1'b0, 32'h1234, 32'h0);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/branch_resolve_bht.md
# branch_resolve_bht

Execute-stage branch resolution unit with an integrated, parametrised branch target buffer and 2-bit saturating direction counters. It gives fetch a combinational next-PC prediction and resolves each branch in EX against the prediction carried down the pipe. On a misprediction it issues a registered redirect/flush and trains the table. A sweep FSM clears the table after reset or on request.

## Interface
- WIDTH, 32, PC/data width in bits
- IDX_BITS, 4, table index bits; ENTRIES = 2^IDX_BITS
- CNT_WIDTH, 16, mispredict statistics counter width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_F_PC  in  WIDTH  fetch PC for lookup
- o_F_PPC  out  WIDTH  predicted next fetch PC (combinational)
- o_F_Taken  out  1  prediction is taken (combinational)
- i_EX_Valid  in  1  EX holds a valid control-flow instruction to resolve
- i_EX_PC  in  WIDTH  address of the EX instruction
- i_ALU_rslt  in  WIDTH  computed branch/jump target
- i_Taken  in  1  actual branch outcome
- i_PPC  in  WIDTH  predicted next PC carried with the instruction
- i_Clear_Tbl  in  1  one-cycle request to invalidate the whole table
- o_Redirect  out  1  registered one-cycle redirect and flush pulse
- o_New_PC  out  WIDTH  registered correct next PC, valid when o_Redirect=1
- o_Ready  out  1  table in RUN state
- o_Mispred_Cnt  out  CNT_WIDTH  saturating mispredict count

## Operation
- Index = PC[IDX_BITS+1:2]. Tag = PC[WIDTH-1:IDX_BITS+2].
- Each entry holds valid, tag, target[WIDTH], and cnt[1:0].
- Lookup:
  - hit = valid & tag match & state RUN.
  - o_F_Taken = hit & cnt[1].
  - o_F_PPC = o_F_Taken ? target : i_F_PC+4.
  - The +4 wraps modulo 2^WIDTH.
- Resolve occurs when i_EX_Valid=1 and o_Redirect=0. An instruction in EX during the redirect cycle is wrong-path and is ignored entirely.
- Resolve computation:
  - actual = i_Taken ? i_ALU_rslt : i_EX_PC+4 (wrapping).
  - mispredict = (actual != i_PPC), a full WIDTH compare.
- Table update happens on resolve, in RUN state only:
  - hit: cnt increments (saturating at 3) if taken, decrements (saturating at 0) if not; target <= i_ALU_rslt if taken.
  - miss and taken: allocate the entry with valid=1, new tag, target=i_ALU_rslt, cnt=2'b10.
  - miss and not taken: no write.
- FSM states:
  - INIT: a sweep pointer clears valid for one entry per cycle, from 0 to ENTRIES-1. After the last entry the FSM goes to RUN.
  - RUN: i_Clear_Tbl=1 moves to INIT with pointer 0 on the next edge. No table update occurs in that cycle.
  - i_Clear_Tbl is ignored while in INIT.
- Redirect and statistics operate in both states. A resolve during INIT still produces a correct redirect.
- o_Mispred_Cnt increments on each mispredicting resolve and holds at all-ones.

## Timing
- Reset values:
  - o_Redirect=0, o_New_PC=0, o_Mispred_Cnt=0, o_Ready=0.
  - State INIT, pointer 0.
  - Stored targets, tags, and counters are don't-care because valid is cleared by the sweep.
- Reset asserted mid-INIT or mid-RUN restarts the sweep from 0.
- INIT lasts exactly ENTRIES cycles after reset release. o_Ready goes to 1 in the cycle after the last clear.
- Lookup is zero-latency. A same-cycle write to the indexed entry is not visible until the next cycle (read-old).
- Resolve to o_Redirect/o_New_PC has 1-cycle latency. o_Redirect is high for exactly one cycle per mispredict.
- Back-to-back mispredicts are impossible because of the shadow rule.
- A table write and the counter increment land on the same edge as o_Redirect rises.

## Test plan
- Reset, WIDTH=32, IDX_BITS=4:
  - o_Ready=0 for 16 cycles, then 1.
  - All outputs 0 during this time.
  - Lookup 0x100 gives o_F_PPC=0x104, o_F_Taken=0.
- Resolve i_EX_PC=0x100, i_Taken=1, i_ALU_rslt=0x200, i_PPC=0x104:
  - Next cycle o_Redirect=1, o_New_PC=0x200, o_Mispred_Cnt=1.
  - Lookup 0x100 then gives 0x200 with taken=1.
- Counter hysteresis at 0x100:
  - 3 more taken resolves saturate cnt=3.
  - One not-taken resolve (i_PPC=0x200) gives a redirect to 0x104, and 0x100 still predicts 0x200.
  - A second not-taken resolve makes the lookup predict 0x104.
- Alias: after 0x100 is allocated, lookup 0x140 (same index 0, different tag) gives 0x144, taken=0.
- Shadow rule:
  - Mispredict at cycle t; at t+1 present another mispredicting resolve.
  - o_Redirect pulses once, o_Mispred_Cnt rises by 1, and the table is unchanged by the second resolve.
- Clear and wrap:
  - i_Clear_Tbl in RUN drops o_Ready for 16 cycles, and all lookups miss.
  - Reset asserted at sweep pointer 7 restarts the full 16-cycle INIT.
  - Resolve i_EX_PC=0xFFFFFFFC, not taken, i_PPC=0x0 gives no redirect.
